// File: rtl/fifo_burst_packer_if.sv
// Burst output stream of fifo_burst_packer: a valid/ready beat with a last flag
// and the beat count of the burst the beat belongs to.
interface fifo_burst_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 4
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic [LEN_W-1:0]      len;

  modport master (output data, valid, last, len, input ready);
  modport slave  (input data, valid, last, len, output ready);
endinterface

// File: rtl/fifo_burst_packer.sv
// Drains a first-word-visible FIFO in bursts of up to BURST_LEN beats onto a
// registered valid/ready stream; partial bursts leave on idle timeout or flush.
module fifo_burst_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 64,
  parameter int LEN_W      = $clog2(BURST_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  input  logic [ADDR_WIDTH:0]   fifo_counter_i,
  output logic                  fifo_rd_valid_o,
  input  logic                  flush_i,
  output logic                  busy_o,
  fifo_burst_packer_if.master   m_if
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]    BURST_CNT   = CW'(BURST_LEN);
  localparam logic [LEN_W-1:0] BURST_LEN_L = LEN_W'(BURST_LEN);
  localparam logic [TW-1:0]    TIMER_MAX   = TW'(TIMEOUT);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      pops_q, pops_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  start, pop, hs, occupied;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      pops_q  <= '0;
      timer_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pops_q  <= pops_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pops_d   = pops_q;
    timer_d  = timer_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;

    occupied = (fifo_counter_i != '0);
    hs       = valid_q && m_if.ready;
    start    = (state_q == IDLE) &&
               ((fifo_counter_i >= BURST_CNT) ||
                (occupied && (TIMEOUT != 0) && (timer_q == TIMER_MAX)) ||
                (occupied && flush_i));
    pop      = (state_q == BURST) && (pops_q < len_q) &&
               (!valid_q || m_if.ready) && !fifo_empty_i;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = (fifo_counter_i >= BURST_CNT) ? BURST_LEN_L : LEN_W'(fifo_counter_i);
          pops_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (hs && last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pop refills the output register in the same cycle the previous beat leaves.
    if (pop) begin
      data_d  = fifo_data_i;
      valid_d = 1'b1;
      last_d  = (pops_q == len_q - LEN_W'(1));
      pops_d  = pops_q + LEN_W'(1);
    end else if (hs) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if ((state_q == BURST) || !occupied || start) begin
      timer_d = '0;
    end else if ((fifo_counter_i < BURST_CNT) && (timer_q != TIMER_MAX)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  assign fifo_rd_valid_o = pop;
  assign busy_o          = (state_q == BURST);
  assign m_if.data       = data_q;
  assign m_if.valid      = valid_q;
  assign m_if.last       = last_q;
  assign m_if.len        = len_q;

endmodule

// File: tb/tb_fifo_burst_packer.sv
// Directed bench for fifo_burst_packer: a behavioural first-word-visible FIFO
// feeds the DUT and a negedge monitor captures every completed output beat.
module tb_fifo_burst_packer;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int BL    = 8;
  localparam int TO    = 64;
  localparam int LW    = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifoData;
  logic          fifoEmpty;
  logic [AW:0]   fifoCounter;
  logic          rdValid;
  logic          flush = 1'b0;
  logic          busy;
  logic          wrEn  = 1'b0;
  logic [DW-1:0] wrData = '0;

  int checks   = 0;
  int failures = 0;
  int cycleCnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  fifo_burst_packer_if #(.DATA_WIDTH(DW), .LEN_W(LW)) mIf ();

  fifo_burst_packer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_data_i    (fifoData),
    .fifo_empty_i   (fifoEmpty),
    .fifo_counter_i (fifoCounter),
    .fifo_rd_valid_o(rdValid),
    .flush_i        (flush),
    .busy_o         (busy),
    .m_if           (mIf)
  );

  // Behavioural FIFO sharing the DUT reset.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW-1:0] rdPtr, wrPtr;
  logic [AW:0]   cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else begin
      if (wrEn) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (rdValid) rdPtr <= rdPtr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wrEn} - {{AW{1'b0}}, rdValid};
    end
  end

  assign fifoData    = mem[rdPtr];
  assign fifoEmpty   = (cnt == '0);
  assign fifoCounter = cnt;

  logic [DW-1:0] captData [$];
  logic          captLast [$];
  logic [LW-1:0] captLen  [$];
  int            popCount      = 0;
  int            busyRises     = 0;
  int            busyRiseCycle = 0;
  logic          prevBusy  = 1'b0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData;
  logic          prevLast;
  logic [LW-1:0] prevLen;

  // A stalled beat must keep data, last and len until it is accepted.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prevBusy  = 1'b0;
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checks++;
        if (mIf.data !== prevData || mIf.last !== prevLast || mIf.len !== prevLen) begin
          failures++;
          $display("[TB] FAIL stall_hold data=%h/%h last=%b/%b len=%0d/%0d (actual/required)",
                   mIf.data, prevData, mIf.last, prevLast, mIf.len, prevLen);
        end
      end
      if (rdValid) popCount++;
      if (busy && !prevBusy) begin
        busyRises++;
        busyRiseCycle = cycleCnt;
      end
      if (mIf.valid && mIf.ready) begin
        captData.push_back(mIf.data);
        captLast.push_back(mIf.last);
        captLen.push_back(mIf.len);
      end
      prevBusy  = busy;
      prevStall = mIf.valid && !mIf.ready;
      prevData  = mIf.data;
      prevLast  = mIf.last;
      prevLen   = mIf.len;
    end
  end

  task automatic clearCapture();
    captData.delete();
    captLast.delete();
    captLen.delete();
    popCount = 0;
  endtask

  task automatic writeWords(input logic [DW-1:0] base, input int n, output int firstEdge);
    firstEdge = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) firstEdge = cycleCnt + 1;
      wrEn   = 1'b1;
      wrData = base + DW'(i);
    end
    @(posedge clk); #1;
    wrEn = 1'b0;
  endtask

  task automatic waitBeats(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (captData.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (captData.size() < n) begin
      failures++;
      $display("[TB] FAIL %s_wait beats=%0d required=%0d", name, captData.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    wrEn      = 1'b0;
    flush     = 1'b0;
    mIf.ready = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (mIf.valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", mIf.valid); end
    if (mIf.last  !== 1'b0) begin failures++; $display("[TB] FAIL reset_last got=%b exp=0", mIf.last); end
    if (mIf.len   !== '0)   begin failures++; $display("[TB] FAIL reset_len got=%0d exp=0", mIf.len); end
    if (mIf.data  !== '0)   begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", mIf.data); end
    if (busy      !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    if (rdValid   !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdvalid got=%b exp=0", rdValid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks += 2;
    if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL post_reset_busy got=%b exp=0", busy); end
    if (mIf.valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_valid got=%b exp=0", mIf.valid); end
  endtask

  task automatic test_full_burst();
    int fe, r0;
    logic [DW-1:0] exp;
    clearCapture();
    mIf.ready = 1'b1;
    r0 = busyRises;
    writeWords(32'h10, 8, fe);
    waitBeats(8, 40, "full");
    checks += 6;
    if (busyRiseCycle !== fe + 8) begin failures++; $display("[TB] FAIL full_start_edge got=%0d exp=%0d", busyRiseCycle, fe + 8); end
    if (busyRises - r0 !== 1)     begin failures++; $display("[TB] FAIL full_bursts got=%0d exp=1", busyRises - r0); end
    if (captData.size() !== 8)    begin failures++; $display("[TB] FAIL full_beats got=%0d exp=8", captData.size()); end
    if (popCount !== 8)           begin failures++; $display("[TB] FAIL full_pops got=%0d exp=8", popCount); end
    if (fifoCounter !== '0)       begin failures++; $display("[TB] FAIL full_fifo_count got=%0d exp=0", fifoCounter); end
    if (busy !== 1'b0)            begin failures++; $display("[TB] FAIL full_busy_after got=%b exp=0", busy); end
    for (int i = 0; i < 8 && i < captData.size(); i++) begin
      exp = 32'h10 + DW'(i);
      checks += 3;
      if (captData[i] !== exp)             begin failures++; $display("[TB] FAIL full_data[%0d] got=%h exp=%h", i, captData[i], exp); end
      if (captLast[i] !== (i == 7))        begin failures++; $display("[TB] FAIL full_last[%0d] got=%b exp=%b", i, captLast[i], (i == 7)); end
      if (captLen[i]  !== LW'(8))          begin failures++; $display("[TB] FAIL full_len[%0d] got=%0d exp=8", i, captLen[i]); end
    end
  endtask

  task automatic test_timeout();
    int fe;
    logic [DW-1:0] exp;
    clearCapture();
    mIf.ready = 1'b1;
    writeWords(32'h20, 3, fe);
    waitBeats(3, 120, "timeout");
    checks += 4;
    if (busyRiseCycle !== fe + 65) begin failures++; $display("[TB] FAIL timeout_start_edge got=%0d exp=%0d", busyRiseCycle - fe, 65); end
    if (captData.size() !== 3)     begin failures++; $display("[TB] FAIL timeout_beats got=%0d exp=3", captData.size()); end
    if (popCount !== 3)            begin failures++; $display("[TB] FAIL timeout_pops got=%0d exp=3", popCount); end
    if (fifoCounter !== '0)        begin failures++; $display("[TB] FAIL timeout_fifo_count got=%0d exp=0", fifoCounter); end
    for (int i = 0; i < 3 && i < captData.size(); i++) begin
      exp = 32'h20 + DW'(i);
      checks += 3;
      if (captData[i] !== exp)      begin failures++; $display("[TB] FAIL timeout_data[%0d] got=%h exp=%h", i, captData[i], exp); end
      if (captLast[i] !== (i == 2)) begin failures++; $display("[TB] FAIL timeout_last[%0d] got=%b exp=%b", i, captLast[i], (i == 2)); end
      if (captLen[i]  !== LW'(3))   begin failures++; $display("[TB] FAIL timeout_len[%0d] got=%0d exp=3", i, captLen[i]); end
    end
  endtask

  task automatic test_flush();
    int fe, flushEdge, r0;
    logic [DW-1:0] exp;
    clearCapture();
    mIf.ready = 1'b1;
    writeWords(32'h30, 2, fe);
    repeat (3) @(posedge clk);
    #1;
    flush     = 1'b1;
    flushEdge = cycleCnt + 1;
    @(posedge clk); #1;
    flush = 1'b0;
    waitBeats(2, 20, "flush");
    checks += 2;
    if (busyRiseCycle !== flushEdge) begin failures++; $display("[TB] FAIL flush_start_edge got=%0d exp=%0d", busyRiseCycle, flushEdge); end
    if (captData.size() !== 2)       begin failures++; $display("[TB] FAIL flush_beats got=%0d exp=2", captData.size()); end
    for (int i = 0; i < 2 && i < captData.size(); i++) begin
      exp = 32'h30 + DW'(i);
      checks += 3;
      if (captData[i] !== exp)      begin failures++; $display("[TB] FAIL flush_data[%0d] got=%h exp=%h", i, captData[i], exp); end
      if (captLast[i] !== (i == 1)) begin failures++; $display("[TB] FAIL flush_last[%0d] got=%b exp=%b", i, captLast[i], (i == 1)); end
      if (captLen[i]  !== LW'(2))   begin failures++; $display("[TB] FAIL flush_len[%0d] got=%0d exp=2", i, captLen[i]); end
    end
    r0 = busyRises;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (10) @(negedge clk);
    checks += 3;
    if (busyRises !== r0)      begin failures++; $display("[TB] FAIL flush_empty_start got=%0d exp=0", busyRises - r0); end
    if (captData.size() !== 2) begin failures++; $display("[TB] FAIL flush_empty_beats got=%0d exp=2", captData.size()); end
    if (busy !== 1'b0)         begin failures++; $display("[TB] FAIL flush_empty_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    int fe, k;
    logic [DW-1:0] exp;
    clearCapture();
    mIf.ready = 1'b0;
    writeWords(32'h40, 8, fe);
    k = 0;
    while (captData.size() < 8 && k < 80) begin
      @(posedge clk); #1;
      mIf.ready = ~mIf.ready;
      k++;
    end
    mIf.ready = 1'b1;
    waitBeats(8, 20, "backpressure");
    checks += 3;
    if (captData.size() !== 8) begin failures++; $display("[TB] FAIL bp_beats got=%0d exp=8", captData.size()); end
    if (popCount !== 8)        begin failures++; $display("[TB] FAIL bp_pops got=%0d exp=8", popCount); end
    if (fifoCounter !== '0)    begin failures++; $display("[TB] FAIL bp_fifo_count got=%0d exp=0", fifoCounter); end
    for (int i = 0; i < 8 && i < captData.size(); i++) begin
      exp = 32'h40 + DW'(i);
      checks += 3;
      if (captData[i] !== exp)      begin failures++; $display("[TB] FAIL bp_data[%0d] got=%h exp=%h", i, captData[i], exp); end
      if (captLast[i] !== (i == 7)) begin failures++; $display("[TB] FAIL bp_last[%0d] got=%b exp=%b", i, captLast[i], (i == 7)); end
      if (captLen[i]  !== LW'(8))   begin failures++; $display("[TB] FAIL bp_len[%0d] got=%0d exp=8", i, captLen[i]); end
    end
  endtask

  task automatic test_oversize();
    int fe, r0;
    logic [DW-1:0] exp;
    logic [LW-1:0] expLen;
    logic          expLast;
    clearCapture();
    mIf.ready = 1'b0;
    r0 = busyRises;
    writeWords(32'h50, 20, fe);
    @(posedge clk); #1;
    mIf.ready = 1'b1;
    waitBeats(20, 300, "oversize");
    checks += 4;
    if (captData.size() !== 20) begin failures++; $display("[TB] FAIL over_beats got=%0d exp=20", captData.size()); end
    if (popCount !== 20)        begin failures++; $display("[TB] FAIL over_pops got=%0d exp=20", popCount); end
    if (busyRises - r0 !== 3)   begin failures++; $display("[TB] FAIL over_bursts got=%0d exp=3", busyRises - r0); end
    if (fifoCounter !== '0)     begin failures++; $display("[TB] FAIL over_fifo_count got=%0d exp=0", fifoCounter); end
    for (int i = 0; i < 20 && i < captData.size(); i++) begin
      exp     = 32'h50 + DW'(i);
      expLen  = (i < 16) ? LW'(8) : LW'(4);
      expLast = (i == 7) || (i == 15) || (i == 19);
      checks += 3;
      if (captData[i] !== exp)     begin failures++; $display("[TB] FAIL over_data[%0d] got=%h exp=%h", i, captData[i], exp); end
      if (captLast[i] !== expLast) begin failures++; $display("[TB] FAIL over_last[%0d] got=%b exp=%b", i, captLast[i], expLast); end
      if (captLen[i]  !== expLen)  begin failures++; $display("[TB] FAIL over_len[%0d] got=%0d exp=%0d", i, captLen[i], expLen); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int fe, k;
    clearCapture();
    mIf.ready = 1'b1;
    writeWords(32'h60, 8, fe);
    k = 0;
    while (captData.size() < 4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (captData.size() < 4) begin failures++; $display("[TB] FAIL rst_mid_wait beats=%0d required=4", captData.size()); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (mIf.valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid got=%b exp=0", mIf.valid); end
    if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", busy); end
    if (mIf.len !== '0)     begin failures++; $display("[TB] FAIL rst_mid_len got=%0d exp=0", mIf.len); end
    if (mIf.last !== 1'b0)  begin failures++; $display("[TB] FAIL rst_mid_last got=%b exp=0", mIf.last); end
    if (rdValid !== 1'b0)   begin failures++; $display("[TB] FAIL rst_mid_rdvalid got=%b exp=0", rdValid); end
    clearCapture();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks += 3;
    if (captData.size() !== 0) begin failures++; $display("[TB] FAIL rst_after_beats got=%0d exp=0", captData.size()); end
    if (busy !== 1'b0)         begin failures++; $display("[TB] FAIL rst_after_busy got=%b exp=0", busy); end
    if (mIf.valid !== 1'b0)    begin failures++; $display("[TB] FAIL rst_after_valid got=%b exp=0", mIf.valid); end
  endtask

  initial begin
    mIf.ready = 1'b0;
    test_reset();
    test_full_burst();
    test_timeout();
    test_flush();
    test_backpressure();
    test_oversize();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
